// File: rtl/data_plane_tx.sv
// Burst transmitter: GPP words are queued in a FIFO and sent as PKT_WORDS-long
// bursts tagged with the latched destination. DATA_TX_PAD_EN enables zero-padding of short bursts.
module data_plane_tx #(
    parameter int PKT_WORDS = 5,
    parameter int BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] node_id,
    input  logic        gpp_wtr_dp,
    input  logic [15:0] gpp_tx_data,
    input  logic [15:0] tx_dest_id,
    input  logic        tx_start,
    input  logic        tx_grant,
    output logic [31:0] data_tx_packet,
    output logic        tx_busy,
    output logic        data_tx_complete_flag,
    output logic [3:0]  tx_level,
    output logic        tx_error
);
    localparam logic [15:0] RSVD_ID  = 16'hFFFF;
    localparam logic [31:0] IDLE_PKT = {16'hFFFF, 16'h0000};
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam int CW = $clog2(PKT_WORDS + 1);

    typedef enum logic [1:0] {IDLE, WAIT_GRANT, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   dest_q, dest_d;
    logic [31:0]   pkt_q, pkt_d;
    logic          err_q, err_d;
    logic [15:0]   mem_q [BUF_DEPTH];
    logic          push, pop, load, start_ok, count_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Word-count rule is judged on the level before any same-cycle write.
`ifdef DATA_TX_PAD_EN
    assign count_ok = (level_q != '0);
`else
    assign count_ok = (level_q >= LW'(PKT_WORDS));
`endif

    assign start_ok = (tx_dest_id != node_id) && (tx_dest_id != RSVD_ID) && count_ok;

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        pkt_d   = IDLE_PKT;
        err_d   = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;
        push    = gpp_wtr_dp && (state_q != SEND) && (level_q < LW'(BUF_DEPTH));
        if (gpp_wtr_dp && !push) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (start_ok) begin
                        state_d = WAIT_GRANT;
                        dest_d  = tx_dest_id;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_GRANT: begin
                if (tx_grant) begin
                    state_d = SEND;
                    cnt_d   = CW'(1);
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == CW'(PKT_WORDS)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    load  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading the packet register pops the head; an empty buffer sends a zero pad.
        if (load) begin
            pop   = (level_q != '0);
            pkt_d = {dest_q, pop ? mem_q[rd_ptr_q] : 16'h0000};
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            dest_q   <= RSVD_ID;
            pkt_q    <= IDLE_PKT;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            dest_q   <= dest_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= gpp_tx_data;
    end

    assign data_tx_packet        = pkt_q;
    assign tx_busy               = (state_q != IDLE);
    assign data_tx_complete_flag = (state_q == DONE);
    assign tx_level              = 4'(level_q);
    assign tx_error              = err_q;
endmodule

// File: doc/data_plane_tx.md
DATA_PLANE_TX -- requirements
Module: data_plane_tx

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 5, data words per transfer; must equal the receiver's fixed burst length.
REQ-002 SHALL have parameter BUF_DEPTH, default 8, capacity of the transmit buffer in 16-bit words; BUF_DEPTH >= PKT_WORDS.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port node_id  input  16 (shortint)  this node's id; 16'hFFFF is reserved and never used as a node id.
REQ-006 SHALL have port gpp_wtr_dp  input  1  GPP write strobe; pushes gpp_tx_data into the buffer.
REQ-007 SHALL have port gpp_tx_data  input  16  data word from the GPP.
REQ-008 SHALL have port tx_dest_id  input  16  destination node id, sampled on an accepted tx_start.
REQ-009 SHALL have port tx_start  input  1  GPP request to send one burst.
REQ-010 SHALL have port tx_grant  input  1  control-plane path grant, level.
REQ-011 SHALL have port data_tx_packet  output  32  {dest_id[31:16], data[15:0]}; registered.
REQ-012 SHALL have port tx_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port data_tx_complete_flag  output  1  one-cycle pulse when a burst finishes.
REQ-014 SHALL have port tx_level  output  4  number of words held in the buffer.
REQ-015 SHALL have port tx_error  output  1  one-cycle pulse when a write or start is rejected.

Function
REQ-016 SHALL output the idle packet {16'hFFFF, 16'h0000} in every cycle that is not a SEND data cycle.
REQ-017 SHALL implement the buffer as a FIFO with wrapping read and write pointers modulo BUF_DEPTH.
REQ-018 SHALL accept a write in IDLE or WAIT_GRANT when tx_level < BUF_DEPTH; tx_level increments on the next edge.
REQ-019 SHALL reject a write when the buffer is full or the state is SEND, and pulse tx_error for one cycle on the next edge.
REQ-020 SHALL implement an FSM with states IDLE, WAIT_GRANT, SEND and DONE.
REQ-021 SHALL move from IDLE to WAIT_GRANT on tx_start when all of the following hold, and latch tx_dest_id:
  - tx_dest_id != node_id
  - tx_dest_id != 16'hFFFF
  - the word-count rule (REQ-031) is satisfied
REQ-022 SHALL, on a tx_start in IDLE that fails REQ-021, stay in IDLE and pulse tx_error.
REQ-023 SHALL ignore tx_start outside IDLE, without raising tx_error.
REQ-024 SHALL move from WAIT_GRANT to SEND on the first edge at which tx_grant=1; it waits indefinitely otherwise.
REQ-025 SHALL, in SEND, drive {latched dest, FIFO head} for PKT_WORDS consecutive cycles, pop one word per cycle, and ignore tx_grant.
REQ-026 SHALL place the first data packet on data_tx_packet in the cycle after the edge that sampled tx_grant=1.
REQ-027 SHALL go to DONE after the PKT_WORDS-th word, pulse data_tx_complete_flag for exactly one cycle, then return to IDLE.
REQ-028 SHALL, when a write and tx_start occur in the same IDLE cycle:
  - accept the write
  - evaluate the word-count rule against tx_level before that write.
REQ-029 SHALL leave words beyond PKT_WORDS in the buffer for the next burst.

Reset
REQ-030 SHALL, on rst=1 (asynchronous, including mid-burst), force all of the following:
  - state IDLE, buffer pointers 0, tx_level 0
  - data_tx_packet = {16'hFFFF, 16'h0000}
  - tx_busy = 0, data_tx_complete_flag = 0, tx_error = 0
  - buffered words discarded

Configuration
REQ-031 SHALL use macro DATA_TX_PAD_EN to select the word-count rule applied at tx_start.
  - Defined: a start with 1 <= tx_level < PKT_WORDS is accepted; missing words are sent as 16'h0000 without popping, and tx_level reaches 0.
  - Defined: a start with tx_level = 0 is rejected.
  - Undefined: a start requires tx_level >= PKT_WORDS; otherwise it is rejected per REQ-022.

Verification
REQ-032 SHALL cover the basic burst:
  - Stimulus: write 1,2,3,4,5; start with dest=3, node_id=1; grant after 2 cycles.
  - Response: packets 0x00030001..0x00030005 on 5 consecutive cycles, then one complete pulse; tx_level=0.
REQ-033 SHALL cover self-addressing: start with dest equal to node_id -> tx_error pulse, state IDLE, tx_level unchanged.
REQ-034 SHALL cover buffer overflow and wrap:
  - Stimulus: write 9 words with BUF_DEPTH=8.
  - Response: the 9th write pulses tx_error; two bursts then send words 1-5, then after 3 refills words 6-8 plus the refills, in order.
REQ-035 SHALL cover padding:
  - Stimulus: write 0xAAAA, 0xBBBB and start.
  - Response with DATA_TX_PAD_EN: 0xAAAA, 0xBBBB, 0, 0, 0 are sent.
  - Response without it: tx_error pulses.
REQ-036 SHALL cover reset mid-burst:
  - Stimulus: assert rst during the 3rd SEND cycle.
  - Response: in the same cycle, idle packet 0xFFFF0000, tx_busy=0, tx_level=0, and no complete pulse.
